cpu_control_fsm: RTL and testbench

- Multi-cycle instruction decoder and sequencer for the 8-bit core; it is the consumer of the 4-bit opcode set in opcode_pkg.
- Fetches 16-bit instructions over a valid/ready handshake, owns the PC and the Z/N flags, and drives registered control signals to the register file, ALU and data memory.
- Sits between instruction memory and the datapath.

---
 rtl/opcode_pkg.sv | 72 +++++++
 rtl/instr_field_decode.sv | 24 ++
 rtl/cpu_control_fsm.sv | 233 +++++++++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opcode_pkg.sv
// Shared ISA definitions for the 8-bit core: opcode encoding, controller states,
// write-back select, branch conditions and instruction field positions.
package opcode_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_ADDI = 4'h1,
    OP_SUB  = 4'h2,
    OP_SUBI = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_NOT  = 4'h7,
    OP_LSL  = 4'h8,
    OP_LSR  = 4'h9,
    OP_LDUR = 4'hA,
    OP_STUR = 4'hB,
    OP_CMP  = 4'hC,
    OP_BR   = 4'hD,
    OP_MOV1 = 4'hE,
    OP_MOV2 = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } ctrl_state_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_IMM = 2'b10,
    WB_RN  = 2'b11
  } wb_sel_t;

  typedef enum logic [1:0] {
    BR_ALWAYS = 2'b00,
    BR_Z      = 2'b01,
    BR_NZ     = 2'b10,
    BR_N      = 2'b11
  } br_cond_t;

  localparam int INSTR_W = 16;
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 10;
  localparam int RN_HI   = 9;
  localparam int RN_LO   = 8;
  localparam int RM_HI   = 7;
  localparam int RM_LO   = 6;
  localparam int IMM_HI  = 7;
  localparam int IMM_LO  = 0;

  function automatic logic uses_imm_operand(input opcode_t op);
    return op inside {OP_ADDI, OP_SUBI, OP_LSL, OP_LSR, OP_LDUR, OP_STUR};
  endfunction

  function automatic logic branch_taken(input br_cond_t cond, input logic z, input logic n);
    case (cond)
      BR_ALWAYS: return 1'b1;
      BR_Z:      return z;
      BR_NZ:     return !z;
      default:   return n;
    endcase
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational splitter from the instruction register to its fields, plus the
// ALU immediate-operand select derived from the opcode.
module instr_field_decode
  import opcode_pkg::*;
#(
  parameter int REG_AW = 2
) (
  input  logic [INSTR_W-1:0] i_ir,
  output opcode_t            o_opcode,
  output logic [REG_AW-1:0]  o_rd,
  output logic [REG_AW-1:0]  o_rn,
  output logic [REG_AW-1:0]  o_rm,
  output logic [7:0]         o_imm,
  output logic               o_alu_src_imm
);

  assign o_opcode      = opcode_t'(i_ir[OPC_HI:OPC_LO]);
  assign o_rd          = REG_AW'(i_ir[RD_HI:RD_LO]);
  assign o_rn          = REG_AW'(i_ir[RN_HI:RN_LO]);
  assign o_rm          = REG_AW'(i_ir[RM_HI:RM_LO]);
  assign o_imm         = i_ir[IMM_HI:IMM_LO];
  assign o_alu_src_imm = uses_imm_operand(o_opcode);

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute sequencer: owns PC, IR and Z/N flags and
// drives fully registered control strobes to the register file, ALU and memory.
module cpu_control_fsm
  import opcode_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int REG_AW = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic [PC_W-1:0]    pc,
  output opcode_t            alu_op,
  output logic [REG_AW-1:0]  rd_addr,
  output logic [REG_AW-1:0]  rn_addr,
  output logic [REG_AW-1:0]  rm_addr,
  output logic [7:0]         imm,
  output logic               alu_src_imm,
  output logic               reg_we,
  output wb_sel_t            wb_sel,
  output logic               mem_req,
  output logic               mem_we,
  input  logic               mem_ack,
  input  logic               alu_z,
  input  logic               alu_n,
  output logic               flag_z,
  output logic               flag_n
);

  ctrl_state_t         r_state, w_state_nxt;
  logic [INSTR_W-1:0]  r_ir, w_ir_nxt;
  logic                r_instr_ready, w_instr_ready_nxt;
  logic [PC_W-1:0]     r_pc, w_pc_nxt;
  opcode_t             r_alu_op, w_alu_op_nxt;
  logic [REG_AW-1:0]   r_rd, w_rd_nxt;
  logic [REG_AW-1:0]   r_rn, w_rn_nxt;
  logic [REG_AW-1:0]   r_rm, w_rm_nxt;
  logic [7:0]          r_imm, w_imm_nxt;
  logic                r_alu_src_imm, w_alu_src_imm_nxt;
  logic                r_reg_we, w_reg_we_nxt;
  wb_sel_t             r_wb_sel, w_wb_sel_nxt;
  logic                r_mem_req, w_mem_req_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic                r_flag_z, w_flag_z_nxt;
  logic                r_flag_n, w_flag_n_nxt;

  opcode_t             w_dec_opcode;
  logic [REG_AW-1:0]   w_dec_rd, w_dec_rn, w_dec_rm;
  logic [7:0]          w_dec_imm;
  logic                w_dec_alu_src_imm;

  logic                w_hs;
  logic [PC_W-1:0]     w_pc_inc;
  logic [PC_W-1:0]     w_br_target;

  instr_field_decode #(.REG_AW(REG_AW)) u_decode (
    .i_ir          (r_ir),
    .o_opcode      (w_dec_opcode),
    .o_rd          (w_dec_rd),
    .o_rn          (w_dec_rn),
    .o_rm          (w_dec_rm),
    .o_imm         (w_dec_imm),
    .o_alu_src_imm (w_dec_alu_src_imm)
  );

  assign w_hs        = (r_state == ST_FETCH) && instr_valid && r_instr_ready;
  assign w_pc_inc    = r_pc + PC_W'(1);
  assign w_br_target = PC_W'(r_imm);

  always_comb begin
    // NOTE: every w_ signal gets its hold/default value first so no latch is inferred.
    w_state_nxt       = r_state;
    w_ir_nxt          = r_ir;
    w_instr_ready_nxt = 1'b0;
    w_pc_nxt          = r_pc;
    w_alu_op_nxt      = r_alu_op;
    w_rd_nxt          = r_rd;
    w_rn_nxt          = r_rn;
    w_rm_nxt          = r_rm;
    w_imm_nxt         = r_imm;
    w_alu_src_imm_nxt = r_alu_src_imm;
    w_reg_we_nxt      = 1'b0;
    w_wb_sel_nxt      = r_wb_sel;
    w_mem_req_nxt     = r_mem_req;
    w_mem_we_nxt      = r_mem_we;
    w_flag_z_nxt      = r_flag_z;
    w_flag_n_nxt      = r_flag_n;

    case (r_state)
      ST_IDLE: begin
        w_state_nxt       = ST_FETCH;
        w_instr_ready_nxt = 1'b1;
      end

      ST_FETCH: begin
        if (w_hs) begin
          w_ir_nxt    = instr;
          w_state_nxt = ST_DECODE;
        end else begin
          w_instr_ready_nxt = 1'b1;
        end
      end

      ST_DECODE: begin
        w_alu_op_nxt      = w_dec_opcode;
        w_rd_nxt          = w_dec_rd;
        w_rn_nxt          = w_dec_rn;
        w_rm_nxt          = w_dec_rm;
        w_imm_nxt         = w_dec_imm;
        w_alu_src_imm_nxt = w_dec_alu_src_imm;
        w_state_nxt       = ST_EXEC;
      end

      ST_EXEC: begin
        w_state_nxt = ST_FETCH;
        w_pc_nxt    = w_pc_inc;
        case (r_alu_op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
          OP_ADDI, OP_SUBI, OP_LSL, OP_LSR: begin
            w_reg_we_nxt = 1'b1;
            w_wb_sel_nxt = WB_ALU;
          end
          OP_MOV1: begin
            w_reg_we_nxt = 1'b1;
            w_wb_sel_nxt = WB_IMM;
          end
          OP_MOV2: begin
            w_reg_we_nxt = 1'b1;
            w_wb_sel_nxt = WB_RN;
          end
          OP_CMP: begin
            w_flag_z_nxt = alu_z;
            w_flag_n_nxt = alu_n;
          end
          OP_BR: begin
            // The rd field doubles as the branch condition; flags are only read here.
            if (branch_taken(br_cond_t'(r_ir[RD_HI:RD_LO]), r_flag_z, r_flag_n)) begin
              w_pc_nxt = w_br_target;
            end
          end
          OP_LDUR, OP_STUR: begin
            w_pc_nxt      = r_pc;
            w_mem_req_nxt = 1'b1;
            w_mem_we_nxt  = (r_alu_op == OP_STUR);
            w_state_nxt   = ST_MEM;
          end
          default: ;
        endcase
      end

      ST_MEM: begin
        if (mem_ack) begin
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
          w_pc_nxt      = w_pc_inc;
          if (r_alu_op == OP_LDUR) begin
            // Load write-back strobe lands on the ack edge, so it is visible in WB.
            w_reg_we_nxt = 1'b1;
            w_wb_sel_nxt = WB_MEM;
            w_state_nxt  = ST_WB;
          end else begin
            w_state_nxt  = ST_FETCH;
          end
        end
      end

      ST_WB: begin
        w_state_nxt = ST_FETCH;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_ir          <= '0;
      r_instr_ready <= 1'b0;
      r_pc          <= '0;
      r_alu_op      <= OP_ADD;
      r_rd          <= '0;
      r_rn          <= '0;
      r_rm          <= '0;
      r_imm         <= '0;
      r_alu_src_imm <= 1'b0;
      r_reg_we      <= 1'b0;
      r_wb_sel      <= WB_ALU;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_flag_z      <= 1'b0;
      r_flag_n      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
      r_state       <= w_state_nxt;
      r_ir          <= w_ir_nxt;
      r_instr_ready <= w_instr_ready_nxt;
      r_pc          <= w_pc_nxt;
      r_alu_op      <= w_alu_op_nxt;
      r_rd          <= w_rd_nxt;
      r_rn          <= w_rn_nxt;
      r_rm          <= w_rm_nxt;
      r_imm         <= w_imm_nxt;
      r_alu_src_imm <= w_alu_src_imm_nxt;
      r_reg_we      <= w_reg_we_nxt;
      r_wb_sel      <= w_wb_sel_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_mem_we      <= w_mem_we_nxt;
      r_flag_z      <= w_flag_z_nxt;
      r_flag_n      <= w_flag_n_nxt;
    end
  end

  assign instr_ready = r_instr_ready;
  assign pc          = r_pc;
  assign alu_op      = r_alu_op;
  assign rd_addr     = r_rd;
  assign rn_addr     = r_rn;
  assign rm_addr     = r_rm;
  assign imm         = r_imm;
  assign alu_src_imm = r_alu_src_imm;
  assign reg_we      = r_reg_we;
  assign wb_sel      = r_wb_sel;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign flag_z      = r_flag_z;
  assign flag_n      = r_flag_n;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: directed scenarios plus random programs
// checked against an instruction-level timing and architectural-state model.
module tb_cpu_control_fsm;
  import opcode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [7:0]  pc;
  opcode_t     alu_op;
  logic [1:0]  rd_addr, rn_addr, rm_addr;
  logic [7:0]  imm;
  logic        alu_src_imm;
  logic        reg_we;
  wb_sel_t     wb_sel;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  logic        alu_z;
  logic        alu_n;
  logic        flag_z;
  logic        flag_n;

  int tests_run    = 0;
  int tests_failed = 0;

  // Architectural state of the reference model
  logic [7:0] m_pc;
  logic       m_z;
  logic       m_n;

  cpu_control_fsm #(.PC_W(8), .REG_AW(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .pc          (pc),
    .alu_op      (alu_op),
    .rd_addr     (rd_addr),
    .rn_addr     (rn_addr),
    .rm_addr     (rm_addr),
    .imm         (imm),
    .alu_src_imm (alu_src_imm),
    .reg_we      (reg_we),
    .wb_sel      (wb_sel),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_ack     (mem_ack),
    .alu_z       (alu_z),
    .alu_n       (alu_n),
    .flag_z      (flag_z),
    .flag_n      (flag_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one instruction when the controller is ready and follows it to the next ready.
  // Edge count e is measured from the fetch handshake edge (e = 0).
  task automatic run_instr(input logic [15:0] word, input int k, input logic z_in, input logic n_in);
    logic [3:0] opc;
    logic [1:0] cond;
    logic       is_alu, is_write, is_mem, is_ld, taken, exp_imm_src;
    logic [1:0] exp_wb;
    int         e, ready_edge, hold, n;

    opc         = word[15:12];
    cond        = word[11:10];
    is_alu      = opc inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
                              OP_ADDI, OP_SUBI, OP_LSL, OP_LSR};
    is_write    = is_alu || (opc == OP_MOV1) || (opc == OP_MOV2);
    is_mem      = (opc == OP_LDUR) || (opc == OP_STUR);
    is_ld       = (opc == OP_LDUR);
    exp_imm_src = opc inside {OP_ADDI, OP_SUBI, OP_LSL, OP_LSR, OP_LDUR, OP_STUR};
    exp_wb      = (opc == OP_MOV1) ? 2'b10 : (opc == OP_MOV2) ? 2'b11 : 2'b00;
    taken       = (cond == 2'b00) || (cond == 2'b01 && m_z) ||
                  (cond == 2'b10 && !m_z) || (cond == 2'b11 && m_n);

    instr_valid = 1'b0;
    hold = $urandom_range(0, 2);
    for (int i = 0; i < hold; i++) tick();
    check("ready_before_hs", instr_ready, 1);

    instr       = word;
    instr_valid = 1'b1;
    tick();
    e = 0;
    // Junk on the fetch and memory inputs while they must be ignored
    instr_valid = 1'($urandom_range(0, 1));
    instr       = 16'($urandom);
    mem_ack     = 1'($urandom_range(0, 1));
    check("ready_after_hs", instr_ready, 0);

    tick();
    e++;
    check("alu_op", alu_op, opc);
    check("rd_addr", rd_addr, word[11:10]);
    check("rn_addr", rn_addr, word[9:8]);
    check("rm_addr", rm_addr, word[7:6]);
    check("imm", imm, word[7:0]);
    check("alu_src_imm", alu_src_imm, exp_imm_src);
    check("reg_we_decode", reg_we, 0);
    alu_z = z_in;
    alu_n = n_in;

    tick();
    e++;
    alu_z   = 1'($urandom_range(0, 1));
    alu_n   = 1'($urandom_range(0, 1));
    mem_ack = 1'b0;
    if (!is_mem) begin
      if (opc == OP_CMP) begin
        m_z = z_in;
        m_n = n_in;
      end
      if (opc == OP_BR && taken) m_pc = word[7:0];
      else                       m_pc = m_pc + 8'd1;
      check("reg_we_exec", reg_we, is_write);
      if (is_write) check("wb_sel_exec", wb_sel, exp_wb);
      check("pc_exec", pc, m_pc);
      check("flag_z_exec", flag_z, m_z);
      check("flag_n_exec", flag_n, m_n);
      check("mem_req_exec", mem_req, 0);
      ready_edge = 3;
    end else begin
      check("mem_req_first", mem_req, 1);
      check("mem_we", mem_we, !is_ld);
      check("reg_we_mem", reg_we, 0);
      check("pc_in_mem", pc, m_pc);
      for (int w = 0; w < k; w++) begin
        tick();
        e++;
        check("mem_req_wait", mem_req, 1);
      end
      mem_ack = 1'b1;
      tick();
      e++;
      mem_ack = 1'($urandom_range(0, 1));
      m_pc = m_pc + 8'd1;
      check("mem_req_drop", mem_req, 0);
      check("reg_we_ack", reg_we, is_ld);
      if (is_ld) check("wb_sel_load", wb_sel, 2'b01);
      check("pc_mem_done", pc, m_pc);
      ready_edge = is_ld ? 5 + k : 4 + k;
    end

    tick();
    e++;
    check("reg_we_pulse", reg_we, 0);
    n = 0;
    while (!instr_ready && n < 12) begin
      tick();
      e++;
      n++;
    end
    instr_valid = 1'b0;
    check("ready_latency", e, ready_edge);
    check("pc_hold", pc, m_pc);
    check("flag_z_hold", flag_z, m_z);
    check("flag_n_hold", flag_n, m_n);
  endtask

  task automatic run_random(input int count);
    for (int i = 0; i < count; i++) begin
      run_instr(16'($urandom), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    mem_ack     = 1'b0;
    alu_z       = 1'b0;
    alu_n       = 1'b0;
    m_pc        = '0;
    m_z         = 1'b0;
    m_n         = 1'b0;

    tick();
    tick();
    check("rst_ready", instr_ready, 0);
    check("rst_pc", pc, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_flag_z", flag_z, 0);
    check("rst_flag_n", flag_n, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_imm", imm, 0);
    check("rst_wb_sel", wb_sel, 0);

    rst = 1'b0;
    tick();
    check("ready_after_release", instr_ready, 1);

    // ADDI r1,r0,6
    run_instr(16'h1406, 0, 1'b0, 1'b0);
    // CMP setting Z, taken BR.Z to 0x40
    run_instr(16'hC100, 0, 1'b1, 1'b0);
    run_instr(16'hD440, 0, 1'b0, 1'b0);
    check("br_taken_pc", pc, 8'h40);
    // CMP clearing Z, BR.Z falls through
    run_instr(16'hC100, 0, 1'b0, 1'b0);
    run_instr(16'hD440, 0, 1'b0, 1'b0);
    check("br_not_taken_pc", pc, 8'h42);
    // LDUR with three extra wait cycles, STUR acked in the first MEM cycle
    run_instr(16'hA50C, 3, 1'b0, 1'b0);
    run_instr(16'hB50C, 0, 1'b0, 1'b0);
    // Branch always to 0xFF, then MOV1 wraps the PC
    run_instr(16'hD0FF, 0, 1'b0, 1'b0);
    check("pc_at_ff", pc, 8'hFF);
    run_instr(16'hE8AA, 0, 1'b0, 1'b0);
    check("pc_wrap", pc, 8'h00);
    // Branch to its own address
    run_instr(16'hD000, 0, 1'b0, 1'b0);
    check("br_self_pc", pc, 8'h00);

    run_random(40);

    // Reset in the middle of a load
    run_instr(16'hC000, 0, 1'b1, 1'b1);
    check("pre_rst_flag_z", flag_z, 1);
    check("pre_rst_flag_n", flag_n, 1);
    mem_ack     = 1'b0;
    instr       = 16'hA50C;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    check("abort_mem_req_on", mem_req, 1);
    tick();
    check("abort_mem_req_hold", mem_req, 1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_mem_req", mem_req, 0);
    check("abort_reg_we", reg_we, 0);
    check("abort_pc", pc, 0);
    check("abort_ready", instr_ready, 0);
    m_pc = '0;
    m_z  = 1'b0;
    m_n  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("abort_ready_back", instr_ready, 1);
    check("abort_flag_z", flag_z, 0);
    check("abort_flag_n", flag_n, 0);
    check("abort_pc_after", pc, 0);

    run_random(12);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
